mips_hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined MIPS core. It replaces the fixed load-use check and the fixed 2-stage forwarding logic. The block tracks in-flight register writes in a DEPTH-entry stage scoreboard and decides, at ID, whether the instruction can issue. It computes registered forward selects for the EX operand muxes, supports configurable load latency, and handles a data-memory wait handshake and branch flushes.

---
 rtl/mips_pipe_pkg.sv | 13 +
 rtl/mips_fwd_lookup.sv | 34 +++
 rtl/mips_hazard_scoreboard.sv | 89 ++++++++
 tb/tb_mips_hazard_scoreboard.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared stage indices, forward-select constant and scoreboard entry type
package mips_pipe_pkg;
   localparam int ST_EX  = 0;
   localparam int ST_MEM = 1;
   localparam int ST_WB  = 2;
   localparam int FWD_RF = 0;
   localparam int REG_W  = 5;
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
      logic             is_load;
   } sb_entry_t;
endpackage

// File: rtl/mips_fwd_lookup.sv
// mips_fwd_lookup: per-source hazard/forward decision from the stage scoreboard
// ports: ent (scoreboard, index 0 = EX), src/use_src (operand), hazard, sel (next-cycle forward stage, 0 = register file)
module mips_fwd_lookup
   import mips_pipe_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int RA_W       = 5,
   parameter int SEL_W      = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0] ent,
   input  logic [RA_W-1:0]       src,
   input  logic                  use_src,
   output logic                  hazard,
   output logic [SEL_W-1:0]      sel
);
   logic hit, ld, live;
   int   nxt;
   // scan oldest to youngest so the youngest match wins
   always_comb begin
      hit = 1'b0;
      ld  = 1'b0;
      nxt = 0;
      for (int s = DEPTH - 1; s >= 0; s--)
         if (ent[s].valid && ent[s].dst == src) begin
            hit = 1'b1;
            ld  = ent[s].is_load;
            nxt = s + 1;
         end
      live   = use_src && src != '0 && hit;
      hazard = live && nxt < (ld ? LOAD_STAGE : 1);
      sel    = (live && !hazard && nxt <= DEPTH - 1) ? SEL_W'(nxt) : SEL_W'(FWD_RF);
   end
endmodule

// File: rtl/mips_hazard_scoreboard.sv
// mips_hazard_scoreboard: issue/stall control and registered EX forward selects for the MIPS pipeline
// ports: clk, reset (async active-low), ID instruction fields, flush, mem_ready -> stall, issue, ex_fwd_a/b
// optional HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt outputs
module mips_hazard_scoreboard
   import mips_pipe_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int RA_W       = 5,
   parameter int SEL_W      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wr_en,
   input  logic [RA_W-1:0]  id_wr_reg,
   input  logic             id_is_load,
   input  logic             flush,
   input  logic             mem_ready,
   output logic             stall,
   output logic             issue,
   output logic [SEL_W-1:0] ex_fwd_a,
   output logic [SEL_W-1:0] ex_fwd_b
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt
`endif
);
   sb_entry_t [DEPTH-1:0] ent_q, ent_d;
   logic [SEL_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
   logic haz_a, haz_b;
   mips_fwd_lookup #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .RA_W(RA_W), .SEL_W(SEL_W)) u_fwd_a (
      .ent(ent_q), .src(id_rs), .use_src(id_use_rs), .hazard(haz_a), .sel(sel_a)
   );
   mips_fwd_lookup #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .RA_W(RA_W), .SEL_W(SEL_W)) u_fwd_b (
      .ent(ent_q), .src(id_rt), .use_src(id_use_rt), .hazard(haz_b), .sel(sel_b)
   );
   assign stall    = !mem_ready || (id_valid && (haz_a || haz_b) && !flush);
   assign issue    = id_valid && mem_ready && !stall && !flush;
   assign ex_fwd_a = fwd_a_q;
   assign ex_fwd_b = fwd_b_q;
   // a flush kills the instruction in EX as it moves to stage 1
   always_comb begin
      ent_d   = ent_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (mem_ready) begin
         for (int s = 1; s < DEPTH; s++)
            ent_d[s] = (s == 1 && flush) ? sb_entry_t'('0) : ent_q[s-1];
         ent_d[0] = issue ? sb_entry_t'{valid: id_wr_en && id_wr_reg != '0, dst: id_wr_reg, is_load: id_is_load}
                          : sb_entry_t'('0);
         fwd_a_d  = issue ? sel_a : SEL_W'(FWD_RF);
         fwd_b_d  = issue ? sel_b : SEL_W'(FWD_RF);
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ent_q   <= '0;
         fwd_a_q <= '0;
         fwd_b_q <= '0;
      end else begin
         ent_q   <= ent_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   // with mem_ready high, stall can only come from a hazard
   always_comb begin
      stall_cnt_d = (mem_ready && stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
      flush_cnt_d = (mem_ready && flush && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// tb_mips_hazard_scoreboard: directed and random checks of two configurations against an in-flight instruction list model
module tb_mips_hazard_scoreboard;
   typedef struct packed {
      logic       v;
      logic [4:0] rs, rt;
      logic       ur, ut, we;
      logic [4:0] wr;
      logic       ld;
   } ins_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, flush, mem_ready;
   ins_t cur[2];
   logic st0, st1, is0, is1;
   logic [1:0] fa0, fb0;
   logic [2:0] fa1, fb1;
`ifdef HAZARD_STATS_EN
   logic [31:0] sc0, fc0, sc1, fc1;
`endif
   mips_hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(2)) u0 (
`ifdef HAZARD_STATS_EN
      .stall_cnt(sc0), .flush_cnt(fc0),
`endif
      .clk(clk), .reset(reset), .id_valid(cur[0].v), .id_rs(cur[0].rs), .id_rt(cur[0].rt),
      .id_use_rs(cur[0].ur), .id_use_rt(cur[0].ut), .id_wr_en(cur[0].we), .id_wr_reg(cur[0].wr),
      .id_is_load(cur[0].ld), .flush(flush), .mem_ready(mem_ready),
      .stall(st0), .issue(is0), .ex_fwd_a(fa0), .ex_fwd_b(fb0)
   );
   mips_hazard_scoreboard #(.DEPTH(5), .LOAD_STAGE(3)) u1 (
`ifdef HAZARD_STATS_EN
      .stall_cnt(sc1), .flush_cnt(fc1),
`endif
      .clk(clk), .reset(reset), .id_valid(cur[1].v), .id_rs(cur[1].rs), .id_rt(cur[1].rt),
      .id_use_rs(cur[1].ur), .id_use_rt(cur[1].ut), .id_wr_en(cur[1].we), .id_wr_reg(cur[1].wr),
      .id_is_load(cur[1].ld), .flush(flush), .mem_ready(mem_ready),
      .stall(st1), .issue(is1), .ex_fwd_a(fa1), .ex_fwd_b(fb1)
   );
   int checks = 0, passes = 0, fails = 0;
   int m_n[2];
   logic [4:0] m_dst[2][16];
   bit m_ld[2][16];
   int m_st[2][16];
   int e_fa[2], e_fb[2], p_sa[2], p_sb[2];
   bit p_es[2], e_issue[2], o_stall[2], o_issue[2];
   int unsigned e_sc[2], e_fc[2];
   function automatic int dep(int i);
      return i ? 5 : 3;
   endfunction
   function automatic int lst(int i);
      return i ? 3 : 2;
   endfunction
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // youngest in-flight writer of r decides; its age next cycle must reach the data-ready stage
   function automatic void exp_src(int i, logic [4:0] r, logic u, output bit haz, output int sel);
      int best;
      int nxt;
      best = -1;
      haz  = 1'b0;
      sel  = 0;
      if (!u || r == 5'd0) return;
      for (int k = 0; k < m_n[i]; k++)
         if (m_dst[i][k] == r && (best < 0 || m_st[i][k] < m_st[i][best])) best = k;
      if (best < 0) return;
      nxt = m_st[i][best] + 1;
      if (nxt < (m_ld[i][best] ? lst(i) : 1)) haz = 1'b1;
      else sel = (nxt <= dep(i) - 1) ? nxt : 0;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_n[i]  = 0;
         e_fa[i] = 0;
         e_fb[i] = 0;
         e_sc[i] = 0;
         e_fc[i] = 0;
      end
   endtask
   task automatic set(int i, bit v, logic [4:0] rs, logic [4:0] rt, bit ur, bit ut, bit we, logic [4:0] wr, bit ld);
      cur[i] = '{v: v, rs: rs, rt: rt, ur: ur, ut: ut, we: we, wr: wr, ld: ld};
   endtask
   task automatic tick();
      bit ha, hb, es;
      int sa, sb;
      int n;
      #1;
      for (int i = 0; i < 2; i++) begin
         exp_src(i, cur[i].rs, cur[i].ur, ha, sa);
         exp_src(i, cur[i].rt, cur[i].ut, hb, sb);
         es = !mem_ready || (cur[i].v && (ha || hb) && !flush);
         e_issue[i] = cur[i].v && mem_ready && !es && !flush;
         o_stall[i] = i ? st1 : st0;
         o_issue[i] = i ? is1 : is0;
         chk($sformatf("stall%0d", i), 32'(o_stall[i]), 32'(es));
         chk($sformatf("issue%0d", i), 32'(o_issue[i]), 32'(e_issue[i]));
         p_sa[i] = sa;
         p_sb[i] = sb;
         p_es[i] = es;
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++)
         if (mem_ready) begin
            e_fa[i] = e_issue[i] ? p_sa[i] : 0;
            e_fb[i] = e_issue[i] ? p_sb[i] : 0;
            if (p_es[i] && e_sc[i] != 32'hFFFF_FFFF) e_sc[i]++;
            if (flush && e_fc[i] != 32'hFFFF_FFFF) e_fc[i]++;
            n = 0;
            for (int k = 0; k < m_n[i]; k++)
               if (!(flush && m_st[i][k] == 0) && m_st[i][k] + 1 < dep(i)) begin
                  m_dst[i][n] = m_dst[i][k];
                  m_ld[i][n]  = m_ld[i][k];
                  m_st[i][n]  = m_st[i][k] + 1;
                  n++;
               end
            if (e_issue[i] && cur[i].we && cur[i].wr != 5'd0) begin
               m_dst[i][n] = cur[i].wr;
               m_ld[i][n]  = cur[i].ld;
               m_st[i][n]  = 0;
               n++;
            end
            m_n[i] = n;
         end
      #1;
      chk("fwd_a0", 32'(fa0), 32'(e_fa[0]));
      chk("fwd_b0", 32'(fb0), 32'(e_fb[0]));
      chk("fwd_a1", 32'(fa1), 32'(e_fa[1]));
      chk("fwd_b1", 32'(fb1), 32'(e_fb[1]));
`ifdef HAZARD_STATS_EN
      chk("stall_cnt0", sc0, e_sc[0]);
      chk("flush_cnt0", fc0, e_fc[0]);
      chk("stall_cnt1", sc1, e_sc[1]);
      chk("flush_cnt1", fc1, e_fc[1]);
`endif
   endtask
   logic [1:0] hold_a;
   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      mem_ready = 1'b1;
      set(0, 0, 0, 0, 0, 0, 0, 0, 0);
      set(1, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      chk("rst fwd_a0", 32'(fa0), 0);
      chk("rst fwd_b0", 32'(fb0), 0);
      chk("rst fwd_a1", 32'(fa1), 0);
      chk("rst stall0", 32'(st0), 0);
      @(negedge clk) reset = 1'b1;
      // load-use: one stall, then forward from stage 2
      set(0, 1, 0, 0, 0, 0, 1, 2, 1);
      tick();
      set(0, 1, 2, 4, 1, 1, 1, 3, 0);
      tick();
      chk("t1 stall", 32'(o_stall[0]), 1);
      chk("t1 noissue", 32'(o_issue[0]), 0);
      tick();
      chk("t1 issue", 32'(o_issue[0]), 1);
      chk("t1 fwd_a", 32'(fa0), 2);
      chk("t1 fwd_b", 32'(fb0), 0);
      // ALU producer at distance 1, 2, 3
      set(0, 1, 1, 1, 1, 1, 1, 5, 0);
      tick();
      set(0, 1, 5, 5, 1, 1, 1, 6, 0);
      tick();
      chk("t2 nostall", 32'(o_stall[0]), 0);
      chk("t2 d1 a", 32'(fa0), 1);
      chk("t2 d1 b", 32'(fb0), 1);
      set(0, 1, 1, 1, 1, 1, 1, 5, 0);
      tick();
      set(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set(0, 1, 5, 5, 1, 1, 1, 6, 0);
      tick();
      chk("t2 d2 a", 32'(fa0), 2);
      chk("t2 d2 b", 32'(fb0), 2);
      set(0, 1, 1, 1, 1, 1, 1, 5, 0);
      tick();
      set(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      set(0, 1, 5, 5, 1, 1, 1, 6, 0);
      tick();
      chk("t2 d3 a", 32'(fa0), 0);
      chk("t2 d3 b", 32'(fb0), 0);
      // $0 is never tracked; youngest of two producers wins
      set(0, 1, 0, 0, 0, 0, 1, 0, 1);
      tick();
      set(0, 1, 0, 0, 1, 1, 1, 11, 0);
      tick();
      chk("t3 r0 nostall", 32'(o_stall[0]), 0);
      chk("t3 r0 sel", 32'(fa0), 0);
      set(0, 1, 1, 1, 1, 1, 1, 7, 0);
      tick();
      tick();
      set(0, 1, 7, 7, 1, 1, 1, 12, 0);
      tick();
      chk("t3 youngest", 32'(fa0), 1);
      // memory wait freezes everything
      set(0, 1, 1, 1, 1, 1, 1, 8, 0);
      tick();
      hold_a = fa0;
      set(0, 1, 8, 0, 1, 0, 1, 13, 0);
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4 frozen stall", 32'(o_stall[0]), 1);
         chk("t4 hold fwd", 32'(fa0), 32'(hold_a));
      end
      mem_ready = 1'b1;
      tick();
      chk("t4 resume issue", 32'(o_issue[0]), 1);
      chk("t4 resume fwd", 32'(fa0), 1);
      // flush over a pending load-use hazard
      set(0, 1, 0, 0, 0, 0, 1, 9, 1);
      tick();
      set(0, 1, 9, 0, 1, 0, 1, 14, 0);
      flush = 1'b1;
      tick();
      chk("t5 flush nostall", 32'(o_stall[0]), 0);
      chk("t5 flush noissue", 32'(o_issue[0]), 0);
      chk("t5 flush fwd", 32'(fa0), 0);
      flush = 1'b0;
      tick();
      chk("t5 killed load", 32'(fa0), 0);
      // asynchronous reset mid-stream
      set(0, 1, 1, 1, 1, 1, 1, 10, 0);
      tick();
      set(0, 1, 10, 0, 1, 0, 1, 15, 0);
      tick();
      chk("t5 pre-reset fwd", 32'(fa0), 1);
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("t5 async fwd_a", 32'(fa0), 0);
      chk("t5 async fwd_b", 32'(fb0), 0);
      set(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) reset = 1'b1;
      // deep configuration: two load-use stalls, then forward from stage 3
      set(1, 1, 0, 0, 0, 0, 1, 2, 1);
      tick();
      set(1, 1, 2, 4, 1, 1, 1, 3, 0);
      tick();
      chk("t6 stall1", 32'(o_stall[1]), 1);
      tick();
      chk("t6 stall2", 32'(o_stall[1]), 1);
      tick();
      chk("t6 issue", 32'(o_issue[1]), 1);
      chk("t6 fwd", 32'(fa1), 3);
`ifdef HAZARD_STATS_EN
      chk("t6 stall_cnt", sc1, 2);
`endif
      // random traffic; a stalled instruction stays in ID
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++)
            if (o_issue[i] || !cur[i].v)
               set(i, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
         if (!(flush && !mem_ready)) flush = $urandom_range(0, 9) == 0;
         mem_ready = $urandom_range(0, 7) != 0;
         tick();
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
